// File: rtl/seven_seg_pkg.sv
// Shared glyph constants for the seven-segment scanner.
// All glyphs are active low, ordered {DP,G,F,E,D,C,B,A}, with DP off.
package seven_seg_pkg;

    localparam logic [7:0] SEG_HEX [0:15] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hA7, 8'hA1, 8'h86, 8'h8E
    };

    localparam logic [7:0] SEG_L     = 8'hC7;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Index 0 is the leftmost message digit (NUM_DIGITS-1).
    localparam logic [7:0] MSG_LOSE [0:3] = '{SEG_L, SEG_HEX[0], SEG_HEX[5], SEG_HEX[14]};

endpackage

// File: rtl/seven_seg_mux_if.sv
// Display-side bundle between game/score logic and the seven-segment scanner.
interface seven_seg_mux_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_mask;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic                    blank_lz;
    logic                    lose;
    logic [7:0]              CA;
    logic [7:0]              AN;

    modport master (
        output value, dp_mask, blink_mask, blank_lz, lose,
        input  CA, AN
    );

    modport slave (
        input  value, dp_mask, blink_mask, blank_lz, lose,
        output CA, AN
    );
endinterface

// File: rtl/seven_seg_decoder.sv
// Combinational hex nibble to active-low seven-segment map (no DP).
module seven_seg_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_HEX[nibble_i][6:0];
    end

endmodule

// File: rtl/seven_seg_mux.sv
// Time-multiplexed seven-segment driver with DP, leading-zero blanking,
// per-digit blink and a "LOSE" overlay on the top four digits.
module seven_seg_mux
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 8,
    parameter int REFRESH_TICKS = 100000,
    parameter int BLINK_TICKS   = 50000000
) (
    input  logic             CLK,
    input  logic             RST,
    seven_seg_mux_if.slave   bus
);

    localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int RW   = $clog2(REFRESH_TICKS);
    localparam int BW   = $clog2(BLINK_TICKS);

    logic [RW-1:0]         rcnt_q;
    logic [IDXW-1:0]       idx_q;
    logic [BW-1:0]         bcnt_q;
    logic                  phase_q;
    logic [7:0]            ca_q, ca_d;
    logic [7:0]            an_q, an_d;

    logic [NUM_DIGITS-1:0] msg;
    logic [NUM_DIGITS-1:0] lz;
    logic                  zero_run;
    logic [3:0]            nib;
    logic [6:0]            seg;
    logic [1:0]            msg_sel;
    logic                  blank_cur;

    // Walk from the top digit down; message digits are skipped so the
    // zero run starts at the highest value digit.
    always_comb begin
        msg      = '0;
        lz       = '0;
        zero_run = 1'b1;
        for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
            if (bus.lose && j < 4) begin
                msg[NUM_DIGITS-1-j] = 1'b1;
            end else begin
                zero_run = zero_run && (bus.value[4*(NUM_DIGITS-1-j) +: 4] == 4'd0);
                lz[NUM_DIGITS-1-j] = zero_run && (j != NUM_DIGITS-1);
            end
        end
    end

    assign nib     = bus.value[{idx_q, 2'b00} +: 4];
    assign msg_sel = 2'(IDXW'(NUM_DIGITS-1) - idx_q);

    seven_seg_decoder u_dec (
        .nibble_i (nib),
        .seg_o    (seg)
    );

    always_comb begin
        blank_cur = !msg[idx_q] &&
                    ((bus.blank_lz && lz[idx_q]) || (bus.blink_mask[idx_q] && !phase_q));
        an_d = '1;
        ca_d = SEG_BLANK;
        if (!blank_cur) begin
            an_d = ~(8'd1 << idx_q);
            ca_d = msg[idx_q] ? MSG_LOSE[msg_sel] : {~bus.dp_mask[idx_q], seg};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rcnt_q  <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            phase_q <= 1'b1;
            ca_q    <= '1;
            an_q    <= '1;
        end else begin
            ca_q <= ca_d;
            an_q <= an_d;
            if (rcnt_q == RW'(REFRESH_TICKS-1)) begin
                rcnt_q <= '0;
                idx_q  <= (idx_q == IDXW'(NUM_DIGITS-1)) ? '0 : idx_q + 1'b1;
            end else begin
                rcnt_q <= rcnt_q + 1'b1;
            end
            if (bcnt_q == BW'(BLINK_TICKS-1)) begin
                bcnt_q  <= '0;
                phase_q <= ~phase_q;
            end else begin
                bcnt_q <= bcnt_q + 1'b1;
            end
        end
    end

    assign bus.CA = ca_q;
    assign bus.AN = an_q;

endmodule

// File: tb/tb_seven_seg_mux.sv
// Directed self-checking bench for seven_seg_mux (8 digits, 4-cycle slots, 16-cycle blink).
module tb_seven_seg_mux;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    localparam logic [7:0] HEXG [0:7] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8
    };

    seven_seg_mux_if #(.NUM_DIGITS(8)) bus ();

    seven_seg_mux #(
        .NUM_DIGITS    (8),
        .REFRESH_TICKS (4),
        .BLINK_TICKS   (16)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Release lands 1 time unit after an edge, so the next tick is edge 1.
    task automatic do_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic set_idle;
        bus.value      = 32'h76543210;
        bus.dp_mask    = '0;
        bus.blink_mask = '0;
        bus.blank_lz   = 1'b0;
        bus.lose       = 1'b0;
    endtask

    task automatic test_reset;
        set_idle;
        rst = 1'b1;
        tick;
        tick;
        checks++;
        if (bus.AN !== 8'hFF) begin
            $display("FAIL reset_an got=%h want=ff", bus.AN);
            errors++;
        end
        checks++;
        if (bus.CA !== 8'hFF) begin
            $display("FAIL reset_ca got=%h want=ff", bus.CA);
            errors++;
        end
        rst = 1'b0;
    endtask

    task automatic test_scan;
        logic [7:0] ean;
        int d;
        set_idle;
        do_reset;
        for (int k = 1; k <= 36; k++) begin
            tick;
            d   = ((k - 1) / 4) % 8;
            ean = ~(8'd1 << d);
            checks++;
            if (bus.AN !== ean) begin
                $display("FAIL scan_an edge=%0d got=%h want=%h", k, bus.AN, ean);
                errors++;
            end
            checks++;
            if (bus.CA !== HEXG[d]) begin
                $display("FAIL scan_ca edge=%0d got=%h want=%h", k, bus.CA, HEXG[d]);
                errors++;
            end
        end
    endtask

    task automatic test_blanking;
        logic [7:0] ean, eca;
        int d;
        set_idle;
        bus.blank_lz = 1'b1;
        bus.value    = 32'h00000A05;
        do_reset;
        for (int k = 1; k <= 32; k++) begin
            tick;
            d = ((k - 1) / 4) % 8;
            case (d)
                0:       begin ean = 8'hFE; eca = 8'h92; end
                1:       begin ean = 8'hFD; eca = 8'hC0; end
                2:       begin ean = 8'hFB; eca = 8'h88; end
                default: begin ean = 8'hFF; eca = 8'hFF; end
            endcase
            checks++;
            if (bus.AN !== ean || bus.CA !== eca) begin
                $display("FAIL blank_a05 edge=%0d got=%h/%h want=%h/%h", k, bus.AN, bus.CA, ean, eca);
                errors++;
            end
        end
        bus.value = 32'h0;
        do_reset;
        for (int k = 1; k <= 32; k++) begin
            tick;
            d   = ((k - 1) / 4) % 8;
            ean = (d == 0) ? 8'hFE : 8'hFF;
            eca = (d == 0) ? 8'hC0 : 8'hFF;
            checks++;
            if (bus.AN !== ean || bus.CA !== eca) begin
                $display("FAIL blank_zero edge=%0d got=%h/%h want=%h/%h", k, bus.AN, bus.CA, ean, eca);
                errors++;
            end
        end
    endtask

    task automatic test_dp_blink;
        logic [7:0] ean, eca;
        logic       vis;
        int d;
        set_idle;
        bus.dp_mask = 8'h01;
        do_reset;
        for (int k = 1; k <= 8; k++) begin
            tick;
            eca = (k <= 4) ? 8'h40 : 8'hF9;
            checks++;
            if (bus.CA !== eca) begin
                $display("FAIL dp edge=%0d got=%h want=%h", k, bus.CA, eca);
                errors++;
            end
        end
        // Only digits 1 and 5 blink; digit 5's slot falls in the dark half.
        set_idle;
        bus.blink_mask = 8'h22;
        do_reset;
        for (int k = 1; k <= 40; k++) begin
            tick;
            d   = ((k - 1) / 4) % 8;
            vis = (((k - 1) / 16) % 2) == 0;
            ean = ~(8'd1 << d);
            eca = HEXG[d];
            if ((d == 1 || d == 5) && !vis) begin
                ean = 8'hFF;
                eca = 8'hFF;
            end
            checks++;
            if (bus.AN !== ean || bus.CA !== eca) begin
                $display("FAIL blink22 edge=%0d got=%h/%h want=%h/%h", k, bus.AN, bus.CA, ean, eca);
                errors++;
            end
        end
        bus.blink_mask = 8'hFF;
        do_reset;
        for (int k = 1; k <= 48; k++) begin
            tick;
            d   = ((k - 1) / 4) % 8;
            vis = (((k - 1) / 16) % 2) == 0;
            ean = vis ? ~(8'd1 << d) : 8'hFF;
            eca = vis ? HEXG[d] : 8'hFF;
            checks++;
            if (bus.AN !== ean || bus.CA !== eca) begin
                $display("FAIL blinkff edge=%0d got=%h/%h want=%h/%h", k, bus.AN, bus.CA, ean, eca);
                errors++;
            end
        end
    endtask

    task automatic test_lose;
        logic [7:0] ean, eca;
        int d;
        set_idle;
        bus.lose       = 1'b1;
        bus.value      = 32'h00000012;
        bus.blank_lz   = 1'b1;
        bus.blink_mask = 8'hFF;
        do_reset;
        for (int k = 1; k <= 32; k++) begin
            tick;
            d = ((k - 1) / 4) % 8;
            case (d)
                0:       begin ean = 8'hFE; eca = 8'hA4; end
                1:       begin ean = 8'hFD; eca = 8'hF9; end
                4:       begin ean = 8'hEF; eca = 8'h86; end
                5:       begin ean = 8'hDF; eca = 8'h92; end
                6:       begin ean = 8'hBF; eca = 8'hC0; end
                7:       begin ean = 8'h7F; eca = 8'hC7; end
                default: begin ean = 8'hFF; eca = 8'hFF; end
            endcase
            checks++;
            if (bus.AN !== ean || bus.CA !== eca) begin
                $display("FAIL lose edge=%0d got=%h/%h want=%h/%h", k, bus.AN, bus.CA, ean, eca);
                errors++;
            end
        end
    endtask

    task automatic test_async_reset;
        set_idle;
        bus.blink_mask = 8'h01;
        do_reset;
        repeat (22) tick;
        checks++;
        if (bus.AN !== 8'hDF) begin
            $display("FAIL async_pre got=%h want=df", bus.AN);
            errors++;
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.AN !== 8'hFF || bus.CA !== 8'hFF) begin
            $display("FAIL async_assert got=%h/%h want=ff/ff", bus.AN, bus.CA);
            errors++;
        end
        tick;
        rst = 1'b0;
        tick;
        checks++;
        if (bus.AN !== 8'hFE || bus.CA !== 8'hC0) begin
            $display("FAIL async_release got=%h/%h want=fe/c0", bus.AN, bus.CA);
            errors++;
        end
    endtask

    task automatic test_live_update;
        logic [7:0] ean, eca;
        set_idle;
        do_reset;
        tick;
        checks++;
        if (bus.AN !== 8'hFE || bus.CA !== 8'hC0) begin
            $display("FAIL live_e1 got=%h/%h want=fe/c0", bus.AN, bus.CA);
            errors++;
        end
        tick;
        #2;
        bus.value[3:0] = 4'h9;
        for (int k = 3; k <= 5; k++) begin
            tick;
            ean = (k <= 4) ? 8'hFE : 8'hFD;
            eca = (k <= 4) ? 8'h90 : 8'hF9;
            checks++;
            if (bus.AN !== ean || bus.CA !== eca) begin
                $display("FAIL live edge=%0d got=%h/%h want=%h/%h", k, bus.AN, bus.CA, ean, eca);
                errors++;
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        set_idle;
        test_reset;
        test_scan;
        test_blanking;
        test_dp_blink;
        test_lose;
        test_async_reset;
        test_live_update;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
